sensor_cond_array: RTL and testbench
====================================

SENSOR_COND_ARRAY -- requirements
Module: sensor_cond_array

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of sensor channels (2..8).
REQ-002 SHALL provide parameter DATA_W, default 12, sample width, unsigned.
REQ-003 SHALL provide parameter LOG2_W, default 2, exponential-average weight exponent (W = 2^LOG2_W, 1..5).
REQ-004 SHALL provide parameter FAST_SIM, default 0; when 1, the decimation period shrinks for simulation.
REQ-005 SHALL provide parameter THRES, default 'h400, low-level threshold; parameter HYST, default 'h20, hysteresis band.
REQ-006 SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 smpl_in  input  NUM_CH*DATA_W  raw samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 seed_req  input  NUM_CH  per-channel seed pulse, e.g. on pedaling resume.
REQ-010 ext_mode  input  1  0 selects the internal decimation timer, 1 selects ext_strobe.
REQ-011 ext_strobe  input  1  external sample tick, used only when ext_mode=1.
REQ-012 gate  input  1  forces error to zero, e.g. not pedaling or low battery.
REQ-013 target  input  DATA_W  setpoint for the error channel.
REQ-014 err_sel  input  clog2(NUM_CH)  selects which channel average error is computed against.
REQ-015 avg_out  output  NUM_CH*DATA_W  registered per-channel averages.
REQ-016 avg_vld  output  1  one-cycle pulse when a full update pass completes.
REQ-017 busy  output  1  high while the update sequencer is not IDLE.
REQ-018 below  output  NUM_CH  per-channel low-level flag, with hysteresis.
REQ-019 overrun  output  1  sticky flag, set when a tick arrives while busy.
REQ-020 error  output  DATA_W+1  signed, target minus the selected average.

Function
REQ-021 SHALL run a TIMER_W-bit free counter: TIMER_W = 22, or 16 when FAST_SIM=1; the internal tick fires when all counter bits are 1.
REQ-022 Tick source SHALL be the internal tick when ext_mode=0 and ext_strobe when ext_mode=1; the unused source is ignored.
REQ-023 SHALL implement a sequencer with states IDLE, CALC and DONE.
- IDLE -> CALC on a tick.
- CALC -> DONE after the channel-NUM_CH-1 step.
- DONE -> IDLE unconditionally.
REQ-024 On a tick in IDLE, SHALL snapshot all smpl_in at that edge; later CALC steps use only the snapshot.
REQ-025 CALC SHALL process one channel per cycle in ascending order, using one shared update datapath.
REQ-026 Per-channel accumulator width SHALL be DATA_W+LOG2_W, and the update SHALL be: acc <= acc - (acc >> LOG2_W) + snap.
- No overflow is possible.
- Result is bounded by (2^DATA_W - 1)*W.
REQ-027 SHALL take each channel average as acc[DATA_W+LOG2_W-1 : LOG2_W], registered into avg_out on the DONE edge.
REQ-028 Latency: tick in cycle t -> channel k acc updated at end of cycle t+1+k -> avg_vld high in cycle t+1+NUM_CH, for exactly one cycle.
REQ-029 A tick while busy SHALL be dropped and SHALL set overrun; overrun clears only on rst.
REQ-030 seed_req[k] SHALL load acc[k] <= smpl_in[k] << LOG2_W at the next edge, in any state.
- Seed has priority over a CALC step for the same channel in the same cycle; that step is discarded.
- avg_out is not updated until the next DONE.
REQ-031 On DONE, below[k] SHALL set when avg < THRES, clear when avg >= THRES+HYST, and otherwise hold.
REQ-032 error SHALL be combinational from registered values: 0 when gate=1, else {0,target} - {0,avg_out[err_sel]}, signed DATA_W+1 bits.
REQ-033 err_sel >= NUM_CH SHALL yield error = 0.

Reset
REQ-034 When rst=1 at a clock edge, all of the following SHALL hold after that edge, including when rst arrives mid-CALC (the pass is aborted and no avg_vld is issued):
- timer = 0; sequencer = IDLE; accumulators, snapshots and avg_out = 0.
- avg_vld = 0, busy = 0, overrun = 0.
- below = all ones.

Verification
REQ-035 Constant input: NUM_CH=4, LOG2_W=2, all channels 'h800, ext_mode=1, 40 strobes spaced 10 cycles -> avg_out converges to 'h800 ±1; avg_vld seen 40 times; busy high for 5 cycles per pass.
REQ-036 Seed: seed_req[2] with smpl 'h600 -> avg_out[2] = 'h600 after the next pass; a simultaneous CALC step on channel 2 is discarded.
REQ-037 Overrun: strobe, then a second strobe 2 cycles later -> one avg_vld only; overrun=1 and stays 1 until rst.
REQ-038 Hysteresis: ch0 average 'h3FF -> below[0]=1; average 'h410 -> below[0] still 1; average 'h420 -> below[0]=0.
REQ-039 Error: target 'h500, avg_out[1]='h700, err_sel=1 -> error = -'h200; gate=1 -> error = 0.
REQ-040 Reset mid-CALC: rst in cycle t+2 after a tick -> no avg_vld; all outputs at reset values; FAST_SIM=1 internal tick recurs every 65536 cycles.

Source files
------------

// File: rtl/sensor_cond_array.sv
// Per-channel exponential averaging of NUM_CH sensor samples, with hysteretic low-level flags and a setpoint error.
// Latency: tick in cycle t -> avg_vld in cycle t+1+NUM_CH; avg_out/below refresh on the edge that ends that cycle.
// Backpressure: none; a tick arriving while a pass is in flight is dropped and recorded in sticky overrun.
module sensor_cond_array #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 12,
  parameter int LOG2_W   = 2,
  parameter int FAST_SIM = 0,
  parameter int THRES    = 'h400,
  parameter int HYST     = 'h20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   smpl_in,
  input  logic [NUM_CH-1:0]          seed_req,
  input  logic                       ext_mode,
  input  logic                       ext_strobe,
  input  logic                       gate,
  input  logic [DATA_W-1:0]          target,
  input  logic [$clog2(NUM_CH)-1:0]  err_sel,
  output logic [NUM_CH*DATA_W-1:0]   avg_out,
  output logic                       avg_vld,
  output logic                       busy,
  output logic [NUM_CH-1:0]          below,
  output logic                       overrun,
  output logic signed [DATA_W:0]     error
);

  localparam int TIMER_W = (FAST_SIM != 0) ? 16 : 22;
  localparam int ACC_W   = DATA_W + LOG2_W;
  localparam int SEL_W   = $clog2(NUM_CH);
  localparam logic [DATA_W:0]  LO_LIM  = (DATA_W+1)'(THRES);
  localparam logic [DATA_W:0]  HI_LIM  = (DATA_W+1)'(THRES + HYST);
  localparam logic [SEL_W:0]   NCH     = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [SEL_W-1:0]   ch_idx;
  logic [DATA_W-1:0]  snap    [NUM_CH];
  logic [ACC_W-1:0]   acc     [NUM_CH];
  logic [DATA_W-1:0]  acc_avg [NUM_CH];
  logic [DATA_W-1:0]  avg_r   [NUM_CH];
  logic [ACC_W-1:0]   acc_cur, acc_upd;
  logic [DATA_W-1:0]  sel_avg;
  logic               tick, start, calc_en;

  // Only one tick source is live; the other is ignored entirely.
  assign tick = ext_mode ? ext_strobe : (&timer);

  // Free-running decimation timer; internal tick when it reads all ones.
  always_ff @(posedge clk) begin
    if (rst) timer <= '0;
    else     timer <= timer + 1'b1;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode: CALC walks one channel per cycle, DONE publishes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    avg_vld   = 1'b0;
    calc_en   = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tick) begin
          start     = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        if (ch_idx == LAST_CH) state_nxt = DONE;
      end
      DONE: begin
        avg_vld   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel pointer for the shared update datapath; parked at 0 outside CALC.
  always_ff @(posedge clk) begin
    if (rst || !calc_en) ch_idx <= '0;
    else                 ch_idx <= ch_idx + 1'b1;
  end

  // Capture all inputs at the accepted tick so a pass sees one coherent sample set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= '0;
    end else if (start) begin
      for (int k = 0; k < NUM_CH; k++) snap[k] <= smpl_in[k*DATA_W +: DATA_W];
    end
  end

  // Shared update: acc - acc/W + sample; cannot exceed (2^DATA_W-1)*W so no wrap.
  always_comb begin
    acc_cur = acc[ch_idx];
    acc_upd = acc_cur - (acc_cur >> LOG2_W) + ACC_W'(snap[ch_idx]);
  end

  // Accumulators: a seed pulse wins over the CALC step for that channel in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (seed_req[k])
          acc[k] <= {smpl_in[k*DATA_W +: DATA_W], {LOG2_W{1'b0}}};
        else if (calc_en && (ch_idx == SEL_W'(k)))
          acc[k] <= acc_upd;
      end
    end
  end

  // Average views of the accumulators and the flattened output bus.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      acc_avg[k] = acc[k][ACC_W-1:LOG2_W];
      avg_out[k*DATA_W +: DATA_W] = avg_r[k];
    end
  end

  // Publish averages and update hysteretic low flags once per completed pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) avg_r[k] <= '0;
      below <= '1;
    end else if (state == DONE) begin
      for (int k = 0; k < NUM_CH; k++) begin
        avg_r[k] <= acc_avg[k];
        if ({1'b0, acc_avg[k]} < LO_LIM)       below[k] <= 1'b1;
        else if ({1'b0, acc_avg[k]} >= HI_LIM) below[k] <= 1'b0;
      end
    end
  end

  // Sticky record of ticks lost because a pass was still running.
  always_ff @(posedge clk) begin
    if (rst)                         overrun <= 1'b0;
    else if (tick && state != IDLE)  overrun <= 1'b1;
  end

  // Setpoint error against the selected published average; forced to zero when gated or out of range.
  always_comb begin
    sel_avg = '0;
    if ({1'b0, err_sel} < NCH) sel_avg = avg_r[err_sel];
    error = '0;
    if (!gate) error = {1'b0, target} - {1'b0, sel_avg};
  end

endmodule

// File: tb/tb_sensor_cond_array.sv
// Bench for sensor_cond_array: directed scenarios plus random passes against a per-pass averaging model.
// Latency: checks tick-to-avg_vld timing, busy width and internal timer period from reset.
// Backpressure: exercises dropped ticks (overrun), seeds colliding with CALC and mid-pass reset.
module tb_sensor_cond_array;
  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int W   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH*DW-1:0]   smpl;
  logic [NCH-1:0]      seed_req;
  logic                ext_mode, ext_strobe, gate;
  logic [DW-1:0]       target;
  logic [1:0]          err_sel;
  logic [NCH*DW-1:0]   avg_out;
  logic                avg_vld, busy, overrun;
  logic [NCH-1:0]      below;
  logic [DW:0]         err;

  int total = 0;
  int bad   = 0;

  // Reference state: full-precision accumulators, published averages, flags.
  int       m_acc [NCH];
  int       m_avg [NCH];
  logic [NCH-1:0] m_below;
  logic     m_ovr;

  sensor_cond_array #(.NUM_CH(NCH), .DATA_W(DW), .LOG2_W(2), .FAST_SIM(1),
                      .THRES('h400), .HYST('h20)) dut (
    .clk(clk), .rst(rst), .smpl_in(smpl), .seed_req(seed_req), .ext_mode(ext_mode),
    .ext_strobe(ext_strobe), .gate(gate), .target(target), .err_sel(err_sel),
    .avg_out(avg_out), .avg_vld(avg_vld), .busy(busy), .below(below),
    .overrun(overrun), .error(err));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] exp_err();
    if (gate) return '0;
    return (DW+1)'(int'(target) - m_avg[err_sel]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin m_acc[k] = 0; m_avg[k] = 0; end
    m_below = '1;
    m_ovr   = 1'b0;
  endtask

  // One completed pass in the model: exponential average with weight 1/W, then flag update.
  task automatic model_pass(input int s [NCH], input int seed_ch, input int seed_val);
    for (int k = 0; k < NCH; k++) begin
      if (k == seed_ch) m_acc[k] = seed_val * W;
      else              m_acc[k] = m_acc[k] - m_acc[k] / W + s[k];
      m_avg[k] = m_acc[k] / W;
      if (m_avg[k] < 'h400)       m_below[k] = 1'b1;
      else if (m_avg[k] >= 'h420) m_below[k] = 1'b0;
    end
  endtask

  task automatic chk_outputs(input string tag);
    for (int k = 0; k < NCH; k++)
      chk({tag, "_avg"}, avg_out[k*DW +: DW], m_avg[k]);
    chk({tag, "_below"}, below, m_below);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_err"}, err, exp_err());
  endtask

  // Strobe one pass; optionally seed channel seed_ch in the very cycle its CALC step runs.
  task automatic run_pass(input string tag, input int seed_ch, input logic [DW-1:0] seed_val);
    int n, bc;
    int s [NCH];
    for (int k = 0; k < NCH; k++) s[k] = smpl[k*DW +: DW];
    ext_strobe = 1'b1; step(); ext_strobe = 1'b0;
    n = 1; bc = 0;
    while (!avg_vld && n < 20) begin
      if (busy) bc++;
      if (seed_ch >= 0 && n == seed_ch + 1) begin
        seed_req[seed_ch] = 1'b1;
        smpl[seed_ch*DW +: DW] = seed_val;
      end
      step();
      seed_req = '0;
      n++;
    end
    if (busy) bc++;
    chk({tag, "_latency"}, n, NCH + 1);
    step();
    chk({tag, "_busy_len"}, bc, NCH + 1);
    chk({tag, "_vld_1cyc"}, avg_vld, 1'b0);
    chk({tag, "_busy_off"}, busy, 1'b0);
    model_pass(s, seed_ch, int'(seed_val));
    chk_outputs(tag);
  endtask

  task automatic seed_idle(input int ch, input logic [DW-1:0] v);
    seed_req[ch] = 1'b1;
    smpl[ch*DW +: DW] = v;
    step();
    seed_req = '0;
    m_acc[ch] = int'(v) * W;
  endtask

  initial begin
    int n, cnt, bsy_seen;
    int s [NCH];

    rst = 1'b1; smpl = '0; seed_req = '0; ext_mode = 1'b1; ext_strobe = 1'b0;
    gate = 1'b0; target = 12'h123; err_sel = 2'd0;
    model_reset();
    step(); step();
    rst = 1'b0;
    chk("rst_vld", avg_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk_outputs("rst");

    // Constant 'h800 on every channel, 40 strobes 10 cycles apart.
    for (int k = 0; k < NCH; k++) smpl[k*DW +: DW] = 12'h800;
    for (int p = 0; p < 40; p++) begin
      run_pass("const", -1, '0);
      repeat (4) step();
    end
    for (int k = 0; k < NCH; k++) begin
      n = avg_out[k*DW +: DW];
      chk("const_converge", (n >= 'h7FF && n <= 'h801), 1'b1);
    end

    // Random samples, setpoints and selections.
    for (int p = 0; p < 8; p++) begin
      smpl = {$urandom, $urandom};
      target = 12'($urandom); err_sel = 2'($urandom); gate = 1'($urandom);
      run_pass("rand", -1, '0);
      repeat (2) step();
    end
    gate = 1'b0;

    // Seed on channel 2 coinciding with its CALC step.
    for (int k = 0; k < NCH; k++) smpl[k*DW +: DW] = 12'h300;
    run_pass("seed", 2, 12'h600);
    chk("seed_ch2", avg_out[2*DW +: DW], 12'h600);

    // Second strobe two cycles after the first: dropped, overrun sticky.
    for (int k = 0; k < NCH; k++) s[k] = smpl[k*DW +: DW];
    ext_strobe = 1'b1; step(); ext_strobe = 1'b0; step();
    ext_strobe = 1'b1; step(); ext_strobe = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (avg_vld) cnt++;
      step();
    end
    chk("ovr_one_vld", cnt, 1);
    m_ovr = 1'b1;
    model_pass(s, -1, 0);
    chk_outputs("ovr");
    run_pass("ovr_sticky", -1, '0);

    // Hysteresis on channel 0.
    seed_idle(0, 12'h3FF); run_pass("hyst3ff", -1, '0);
    chk("hyst_3ff", below[0], 1'b1);
    seed_idle(0, 12'h410); run_pass("hyst410", -1, '0);
    chk("hyst_410", below[0], 1'b1);
    seed_idle(0, 12'h420); run_pass("hyst420", -1, '0);
    chk("hyst_420", below[0], 1'b0);
    seed_idle(0, 12'h410); run_pass("hyst410b", -1, '0);
    chk("hyst_410_hold", below[0], 1'b0);

    // Error channel.
    target = 12'h500; err_sel = 2'd1;
    seed_idle(1, 12'h700); run_pass("err", -1, '0);
    chk("err_neg200", err, 13'h1E00);
    gate = 1'b1; #1;
    chk("err_gated", err, 13'h0);
    gate = 1'b0;

    // Reset in cycle t+2 of a pass.
    ext_strobe = 1'b1; step(); ext_strobe = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    chk("midrst_busy", busy, 1'b0);
    chk_outputs("midrst");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (avg_vld) cnt++;
      step();
    end
    chk("midrst_no_vld", cnt, 0);

    // Internal timer: tick at timer==16'hFFFF after reset; stray strobes ignored.
    rst = 1'b1; ext_mode = 1'b0; step(); rst = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      smpl[k*DW +: DW] = 12'($urandom);
      s[k] = smpl[k*DW +: DW];
    end
    n = 0; bsy_seen = 0;
    while (!avg_vld && n < 70000) begin
      ext_strobe = (n < 40) ? n[0] : 1'b0;
      if (n >= 1 && n <= 40 && busy) bsy_seen = 1;
      step();
      n++;
    end
    ext_strobe = 1'b0;
    chk("timer_period", n, 65535 + 1 + NCH);
    chk("timer_ext_ignored", bsy_seen, 0);
    step();
    model_pass(s, -1, 0);
    chk_outputs("timer");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
